// File: rtl/multicycle_control_unit_pkg.sv
// mcu_pkg: shared types and encodings for the multicycle RV32I control unit.
// Holds the FSM state enum, opcode constants, ALU op classes and the
// datapath mux/ALU encodings used by the control unit and its ALU decoder.
package mcu_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: maps ALU op class and instruction fields to ALUControl.
// Ports: aluop (class), funct3, op5 (op[5]), funct7b5 -> alu_control.
module alu_decoder
    import mcu_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // funct7b5 only selects sub for register-register ops; addi ignores it
    assign alu_control = aluop == ALUOP_SUB   ? ALU_SUB :
                         aluop == ALUOP_ADD   ? ALU_ADD :
                         funct3 == 3'b000     ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                         funct3 == 3'b010     ? ALU_SLT :
                         funct3 == 3'b110     ? ALU_OR  :
                         funct3 == 3'b111     ? ALU_AND : ALU_ADD;

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle RV32I datapath.
// Inputs: clk, rst (async active-low), op/funct3/funct7b5 from IR, ALU zero,
// mem_ready handshake. Outputs: memory request/qualifiers, datapath enables
// and mux selects, ALUControl, sticky illegal flag, retired count, state.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);

    state_t state, next;
    aluop_t aluop;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= next;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            instret <= '0;
        else if (next == FETCH && (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ))
            instret <= instret + CNT_W'(1);

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = FETCH;
            FETCH:    next = mem_ready ? DECODE : FETCH;
            DECODE:   next = (op == OP_LW || op == OP_SW) ? MEMADR :
                             op == OP_R   ? EXECUTER :
                             op == OP_I   ? EXECUTEI :
                             op == OP_JAL ? JAL :
                             op == OP_BEQ ? BEQ : TRAP;
            MEMADR:   next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ:  next = FETCH;
            EXECUTER, EXECUTEI, JAL: next = ALUWB;
            TRAP:     next = TRAP;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (state)
            FETCH: begin
                // selects stay put while stalled; only the writes wait for mem_ready
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: RegWrite = 1'b1;
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_SUB;
                PCWrite = zero;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // TRAP is only left through reset, so the flag is sticky by construction
    assign illegal   = state == TRAP;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized check of the control unit against an instruction-level model.
module tb_multicycle_control_unit;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4;
    localparam int S_MEMWB = 5, S_MEMWRITE = 6, S_EXR = 7, S_EXI = 8, S_ALUWB = 9;
    localparam int S_JAL = 10, S_BEQ = 11, S_TRAP = 12;

    logic        clk = 1'b0, rst = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    int checks = 0, errors = 0;
    int exp_ret = 0;

    typedef struct {
        logic        rdy;
        logic [21:0] b;
    } cyc_t;
    cyc_t q[$];

    multicycle_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .illegal(illegal), .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] mk(input int st, input logic ill, req, mw, adr, irw, pcw, rw,
                                       input logic [1:0] asa, asb, imm, res, input logic [2:0] alu);
        return {st[3:0], ill, req, mw, adr, irw, pcw, rw, asa, asb, imm, res, alu};
    endfunction

    function automatic logic [21:0] observed();
        return {state_dbg, illegal, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, ALUControl};
    endfunction

    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == RT && f7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic [21:0] b);
        cyc_t c;
        c.rdy = rdy;
        c.b = b;
        q.push_back(c);
    endtask

    function automatic logic rr();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the cycle-by-cycle expectation for one instruction, then plays it.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, z,
                       input int sf, sm, abort_at);
        q = {};
        for (int i = 0; i < sf; i++) push(1'b0, mk(S_FETCH, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0));
        push(1'b1, mk(S_FETCH, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0));
        push(rr(), mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        case (o)
            LW: begin
                push(rr(), mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
                for (int i = 0; i < sm; i++) push(1'b0, mk(S_MEMREAD, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                push(1'b1, mk(S_MEMREAD, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                push(rr(), mk(S_MEMWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
            end
            SW: begin
                push(rr(), mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
                for (int i = 0; i < sm; i++) push(1'b0, mk(S_MEMWRITE, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                push(1'b1, mk(S_MEMWRITE, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            RT: begin
                push(rr(), mk(S_EXR, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, alu_ref(o, f3, f7)));
                push(rr(), mk(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            IT: begin
                push(rr(), mk(S_EXI, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, alu_ref(o, f3, f7)));
                push(rr(), mk(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            JL: begin
                push(rr(), mk(S_JAL, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0));
                push(rr(), mk(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            BQ: push(rr(), mk(S_BEQ, 0, 0, 0, 0, 0, z, 0, 2, 0, 0, 0, 1));
            default: for (int i = 0; i < 11; i++) push(rr(), mk(S_TRAP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        endcase
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        zero = z;
        foreach (q[i]) begin
            @(negedge clk);
            mem_ready = q[i].rdy;
            #1;
            check($sformatf("op%02h_cyc%0d", o, i), observed(), q[i].b);
            check($sformatf("instret_cyc%0d", i), instret, exp_ret);
            if (i == abort_at) begin
                #2 rst = 1'b0;
                #1;
                check("abort_outputs", observed(), mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                check("abort_instret", instret, 0);
                exp_ret = 0;
                @(negedge clk);
                rst = 1'b1;
                #1;
                check("abort_release", observed(), mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                return;
            end
        end
        if (o inside {LW, SW, RT, IT, JL, BQ}) exp_ret++;
    endtask

    initial begin
        logic [6:0] kinds [6];
        kinds = '{LW, SW, RT, IT, JL, BQ};
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", observed(), mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("reset_instret", instret, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_idle", observed(), mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(RT, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run(LW, 3'b010, 1'b0, 1'b0, 0, 3, -1);
        run(BQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run(BQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run(RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run(IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run(SW, 3'b010, 1'b0, 1'b0, 2, 1, -1);
        run(JL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
        run(LW, 3'b010, 1'b0, 1'b0, 0, 5, 4);
        for (int n = 0; n < 40; n++)
            run(kinds[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), rr(), rr(),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
        run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
